mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_if.sv | 24 ++
 rtl/mem_bus_ctrl.sv | 120 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// CPU request/response bus and output-port stream of the memory bus controller.
// cpu_req is held until the one-cycle cpu_ready pulse; the stream transfers out_data when out_valid && out_ready.
interface mem_bus_if;
  logic        cpu_req;
  logic        cpu_rw;
  logic [31:0] address;
  logic [31:0] datai;
  logic [31:0] data;
  logic        cpu_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        bus_err;

  modport slave (
    input  cpu_req, cpu_rw, address, datai, out_ready,
    output data, cpu_ready, out_data, out_valid, bus_err
  );

  modport master (
    output cpu_req, cpu_rw, address, datai, out_ready,
    input  data, cpu_ready, out_data, out_valid, bus_err
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: CPU access to a word RAM, a FIFO-backed output port
// with status register, and a sticky error flag for unmapped addresses.
module mem_bus_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset,
  mem_bus_if.slave   bus,
  output logic [1:0] state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] OUT_DATA_ADDR   = 32'hFFFF_FF00;
  localparam logic [31:0] OUT_STATUS_ADDR = 32'hFFFF_FF01;

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RESP = 2'd2, STALL = 2'd3} state_t;

  state_t      state;
  logic [31:0] lat_datai;
  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] ram_q;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          accept, is_ram, is_odata, is_ostat, is_unmapped;
  logic          full, pop, push, push_direct, ram_we;
  logic [31:0]   push_data, status;
  logic [AW-1:0] ram_idx;

  assign state_dbg   = state;
  assign accept      = (state == IDLE) && bus.cpu_req;
  assign is_ram      = bus.address < 32'(DEPTH_WORDS);
  assign is_odata    = bus.address == OUT_DATA_ADDR;
  assign is_ostat    = bus.address == OUT_STATUS_ADDR;
  assign is_unmapped = !is_ram && !is_odata && !is_ostat;
  assign ram_idx     = bus.address[AW-1:0];
  assign ram_we      = accept && bus.cpu_rw && is_ram;

  assign full          = count == CW'(FIFO_DEPTH);
  assign bus.out_valid = count != '0;
  assign bus.out_data  = fifo_mem[rd_ptr];
  assign pop           = bus.out_valid && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_direct   = accept && bus.cpu_rw && is_odata && (!full || pop);
  assign push          = push_direct || ((state == STALL) && pop);
  assign push_data     = (state == STALL) ? lat_datai : bus.datai;
  assign status        = {full, 23'b0, 8'(count)};

  // Synchronous read port; the word is consumed in RD_WAIT.
  always_ff @(posedge clock) begin
    if (ram_we && !reset) ram[ram_idx] <= bus.datai;
    ram_q <= ram[ram_idx];
  end

  always_ff @(posedge clock) begin
    if (push && !reset) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.cpu_ready <= 1'b0;
      bus.data      <= '0;
      bus.bus_err   <= 1'b0;
      lat_datai     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            lat_datai <= bus.datai;
            if (is_ram && !bus.cpu_rw) begin
              state <= RD_WAIT;
            end else if (is_odata && bus.cpu_rw && full && !pop) begin
              state <= STALL;
            end else begin
              state         <= RESP;
              bus.cpu_ready <= 1'b1;
              bus.data      <= (is_ostat && !bus.cpu_rw) ? status : '0;
              if (is_unmapped) bus.bus_err <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          state         <= RESP;
          bus.cpu_ready <= 1'b1;
          bus.data      <= ram_q;
        end
        RESP: begin
          state         <= IDLE;
          bus.cpu_ready <= 1'b0;
          bus.data      <= '0;
        end
        STALL: begin
          if (pop) begin
            state         <= RESP;
            bus.cpu_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: RAM access, output FIFO with stall and wrap,
// status register, unmapped errors and mid-transfer reset.
module tb_mem_bus_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] exp_q[$];

  mem_bus_if bus ();

  mem_bus_ctrl #(.DEPTH_WORDS(256), .FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Driver: one CPU transfer, reports latency in cycles and the returned data.
  task automatic do_xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_data, input string name);
    int   lat = 0;
    logic got = 1'b0;
    bus.cpu_req = 1'b1;
    bus.cpu_rw  = rw;
    bus.address = addr;
    bus.datai   = wdata;
    while (!got && lat < 20) begin
      next_cycle();
      lat++;
      if (bus.cpu_ready === 1'b1) got = 1'b1;
      else begin
        checks++;
        if (bus.data !== 32'h0) begin
          errors++;
          $display("FAIL %s_idle_data got %h want 00000000", name, bus.data);
        end
      end
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (bus.data !== exp_data) begin
      errors++;
      $display("FAIL %s_data got %h want %h", name, bus.data, exp_data);
    end
    next_cycle();
    checks++;
    if (bus.cpu_ready !== 1'b0 || bus.data !== 32'h0) begin
      errors++;
      $display("FAIL %s_release got ready=%b data=%h want ready=0 data=0", name, bus.cpu_ready, bus.data);
    end
  endtask

  task automatic out_write(input logic [31:0] v, input string name);
    do_xfer(1'b1, 32'hFFFF_FF00, v, 1, 32'h0, name);
    exp_q.push_back(v);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 20) begin
      guard++;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL %s_pop got valid=%b data=%h want valid=1 data=%h", name, bus.out_valid, bus.out_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      next_cycle();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty got valid=%b want 0", name, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b0;
    checks++;
    if (bus.cpu_ready !== 1'b0 || bus.data !== 32'h0 || bus.out_valid !== 1'b0 ||
        bus.bus_err !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got ready=%b data=%h valid=%b err=%b st=%0d want 0 0 0 0 0",
               bus.cpu_ready, bus.data, bus.out_valid, bus.bus_err, state_dbg);
    end
  endtask

  task automatic test_ram();
    do_xfer(1'b1, 32'd5, 32'hDEAD_BEEF, 1, 32'h0, "ram_wr5");
    do_xfer(1'b0, 32'd5, 32'h0, 2, 32'hDEAD_BEEF, "ram_rd5");
    do_xfer(1'b1, 32'd255, 32'h1234_5678, 1, 32'h0, "ram_wr255");
    do_xfer(1'b1, 32'd0, 32'hA5A5_0001, 1, 32'h0, "ram_wr0");
    do_xfer(1'b0, 32'd255, 32'h0, 2, 32'h1234_5678, "ram_rd255");
    do_xfer(1'b0, 32'd0, 32'h0, 2, 32'hA5A5_0001, "ram_rd0");
  endtask

  task automatic test_fifo_stall();
    int waited = 0;
    bus.out_ready = 1'b0;
    out_write(32'd1, "out_wr1");
    out_write(32'd2, "out_wr2");
    out_write(32'd3, "out_wr3");
    do_xfer(1'b0, 32'hFFFF_FF01, 32'h0, 1, 32'h0000_0003, "status3");
    out_write(32'd4, "out_wr4");
    do_xfer(1'b0, 32'hFFFF_FF01, 32'h0, 1, 32'h8000_0004, "status4");
    bus.cpu_req = 1'b1;
    bus.cpu_rw  = 1'b1;
    bus.address = 32'hFFFF_FF00;
    bus.datai   = 32'd5;
    repeat (3) begin
      next_cycle();
      checks++;
      if (bus.cpu_ready !== 1'b0 || state_dbg !== 2'd3 || bus.data !== 32'h0) begin
        errors++;
        $display("FAIL stall_hold got ready=%b st=%0d data=%h want 0 3 0", bus.cpu_ready, state_dbg, bus.data);
      end
    end
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;
    bus.cpu_req   = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(32'd5);
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.out_data !== 32'd2) begin
      errors++;
      $display("FAIL stall_release got ready=%b head=%h want 1 00000002", bus.cpu_ready, bus.out_data);
    end
    while (bus.cpu_ready === 1'b1 && waited < 5) begin
      waited++;
      next_cycle();
    end
    do_xfer(1'b0, 32'hFFFF_FF01, 32'h0, 1, 32'h8000_0004, "status_after_stall");
    drain("drain_stall");
  endtask

  task automatic test_back_to_back();
    // Pointers start at 1 here, so the next fills wrap the write pointer.
    out_write(32'd10, "b2b_wr10");
    out_write(32'd11, "b2b_wr11");
    out_write(32'd12, "b2b_wr12");
    out_write(32'd13, "b2b_wr13");
    bus.cpu_req   = 1'b1;
    bus.cpu_rw    = 1'b1;
    bus.address   = 32'hFFFF_FF00;
    bus.datai     = 32'd14;
    bus.out_ready = 1'b1;
    next_cycle();
    bus.out_ready = 1'b0;
    bus.cpu_req   = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(32'd14);
    checks++;
    if (bus.cpu_ready !== 1'b1 || bus.out_data !== 32'd11 || state_dbg !== 2'd2) begin
      errors++;
      $display("FAIL b2b_push_pop got ready=%b head=%h st=%0d want 1 0000000b 2",
               bus.cpu_ready, bus.out_data, state_dbg);
    end
    next_cycle();
    do_xfer(1'b0, 32'hFFFF_FF01, 32'h0, 1, 32'h8000_0004, "b2b_status");
    drain("drain_b2b");
  endtask

  task automatic test_unmapped();
    checks++;
    if (bus.bus_err !== 1'b0) begin
      errors++;
      $display("FAIL err_before got %b want 0", bus.bus_err);
    end
    do_xfer(1'b0, 32'h0000_1000, 32'h0, 1, 32'h0, "unmapped_rd");
    checks++;
    if (bus.bus_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b want 1", bus.bus_err);
    end
    do_xfer(1'b1, 32'h0000_0100, 32'hBAD0_BAD0, 1, 32'h0, "unmapped_wr256");
    do_xfer(1'b0, 32'd0, 32'h0, 2, 32'hA5A5_0001, "ram_rd0_intact");
    checks++;
    if (bus.bus_err !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got err=%b valid=%b want 1 0", bus.bus_err, bus.out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    out_write(32'h77, "pre_reset_wr");
    bus.cpu_req = 1'b1;
    bus.cpu_rw  = 1'b0;
    bus.address = 32'd5;
    next_cycle();
    bus.cpu_req = 1'b0;
    checks++;
    if (state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL rd_wait_state got %0d want 1", state_dbg);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.bus_err !== 1'b0 ||
        bus.data !== 32'h0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got ready=%b valid=%b err=%b data=%h st=%0d want 0 0 0 0 0",
               bus.cpu_ready, bus.out_valid, bus.bus_err, bus.data, state_dbg);
    end
    exp_q.delete();
    next_cycle();
    checks++;
    if (bus.cpu_ready !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold got ready=%b st=%0d want 0 0", bus.cpu_ready, state_dbg);
    end
    reset = 1'b0;
    do_xfer(1'b0, 32'd5, 32'h0, 2, 32'hDEAD_BEEF, "post_reset_rd5");
    out_write(32'h99, "post_reset_wr");
    drain("drain_post_reset");
  endtask

  initial begin
    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_rw    = 1'b0;
    bus.address   = 32'h0;
    bus.datai     = 32'h0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ram();
    test_fifo_stall();
    test_back_to_back();
    test_unmapped();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
